uart_transmitter: RTL

Serial transmit stage paired with the UART receiver. It accepts one byte per write strobe and shifts it out on `TxD` as a single frame: start bit, 8 data bits LSB first, optional even parity bit, and stop bit. Its baud timing matches the receiver's 16x sample scheme, so `TxD` can loop straight back into `RxD`. It sits between the host byte interface and the serial line.

---
 rtl/uart_pkg.sv | 40 ++++
 rtl/uart_transmitter_if.sv | 11 +
 rtl/uart_tick_gen.sv | 27 ++
 rtl/uart_transmitter.sv | 120 ++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states, baud codes, divisor lookup and frame sizes.
// Used by the transmitter and reusable by the matching receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_t;

    localparam logic [2:0] BAUD_300    = 3'd0;
    localparam logic [2:0] BAUD_1200   = 3'd1;
    localparam logic [2:0] BAUD_4800   = 3'd2;
    localparam logic [2:0] BAUD_9600   = 3'd3;
    localparam logic [2:0] BAUD_19200  = 3'd4;
    localparam logic [2:0] BAUD_38400  = 3'd5;
    localparam logic [2:0] BAUD_57600  = 3'd6;
    localparam logic [2:0] BAUD_115200 = 3'd7;

    localparam int unsigned FRAME_BITS_PARITY    = 11;
    localparam int unsigned FRAME_BITS_NO_PARITY = 10;
    localparam int unsigned TICKS_PER_BIT        = 16;

    // Each arm folds to a constant, so the lookup becomes a small constant mux.
    function automatic logic [13:0] baud_div(input int unsigned clk_hz, input logic [2:0] code);
        case (code)
            BAUD_300:    return 14'(clk_hz / (16 * 300));
            BAUD_1200:   return 14'(clk_hz / (16 * 1200));
            BAUD_4800:   return 14'(clk_hz / (16 * 4800));
            BAUD_9600:   return 14'(clk_hz / (16 * 9600));
            BAUD_19200:  return 14'(clk_hz / (16 * 19200));
            BAUD_38400:  return 14'(clk_hz / (16 * 38400));
            BAUD_57600:  return 14'(clk_hz / (16 * 57600));
            default:     return 14'(clk_hz / (16 * 115200));
        endcase
    endfunction

endpackage

// File: rtl/uart_transmitter_if.sv
// Host-side byte interface of the UART transmitter.
interface uart_transmitter_if;
    logic       Tx_EN;
    logic       Tx_WR;
    logic [7:0] Tx_DATA;
    logic       Tx_BUSY;
    logic       Tx_DONE;

    modport master (output Tx_EN, Tx_WR, Tx_DATA, input Tx_BUSY, Tx_DONE);
    modport slave  (input Tx_EN, Tx_WR, Tx_DATA, output Tx_BUSY, Tx_DONE);
endinterface

// File: rtl/uart_tick_gen.sv
// 16x oversampling tick generator: one-cycle pulse every DIV clocks for the given baud code.
module uart_tick_gen
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ = 50_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       enable,
    input  logic [2:0] baud_code,
    output logic       tick
);
    logic [13:0] count;
    logic [13:0] div_m1;

    assign div_m1 = baud_div(CLK_HZ, baud_code) - 14'd1;
    assign tick   = enable && (count == div_m1);

    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= tick ? '0 : count + 14'd1;
        end
    end
endmodule

// File: rtl/uart_transmitter.sv
// UART transmit stage: start, 8 data bits LSB first, optional even parity, stop.
// Parity bit is compiled in when UART_TX_PARITY_EN is defined.
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ = 50_000_000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        baud_select,
    uart_transmitter_if.slave host,
    output logic              TxD
);
    uart_state_t state, state_next;
    logic [7:0]  shift, shift_next;
    logic [2:0]  bit_idx, bit_idx_next;
    logic [3:0]  tick_cnt, tick_cnt_next;
    logic [2:0]  baud_q, baud_q_next;
    logic        txd_next;
    logic        done_next;
    logic        accept;
    logic        tick;
    logic        bit_end;

    assign accept  = host.Tx_WR && host.Tx_EN && (state == ST_IDLE);
    assign bit_end = tick && (tick_cnt == 4'd15);

    uart_tick_gen #(.CLK_HZ(CLK_HZ)) u_tick_gen (
        .clk       (clk),
        .reset     (reset),
        .clear     (accept),
        .enable    (state != ST_IDLE),
        .baud_code (baud_q),
        .tick      (tick)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= ST_IDLE;
            shift        <= '0;
            bit_idx      <= '0;
            tick_cnt     <= '0;
            baud_q       <= '0;
            TxD          <= 1'b1;
            host.Tx_BUSY <= 1'b0;
            host.Tx_DONE <= 1'b0;
        end else begin
            state        <= state_next;
            shift        <= shift_next;
            bit_idx      <= bit_idx_next;
            tick_cnt     <= tick_cnt_next;
            baud_q       <= baud_q_next;
            TxD          <= txd_next;
            host.Tx_BUSY <= (state_next != ST_IDLE);
            host.Tx_DONE <= done_next;
        end
    end

    always_comb begin
        state_next    = state;
        shift_next    = shift;
        bit_idx_next  = bit_idx;
        tick_cnt_next = tick ? tick_cnt + 4'd1 : tick_cnt;
        baud_q_next   = baud_q;
        done_next     = 1'b0;

        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_next    = ST_START;
                    shift_next    = host.Tx_DATA;
                    baud_q_next   = baud_select;
                    bit_idx_next  = '0;
                    tick_cnt_next = '0;
                end
            end
            ST_START: begin
                if (bit_end) state_next = ST_DATA;
            end
            ST_DATA: begin
                // Rotate rather than shift: after 8 bits the byte is intact for the parity bit.
                if (bit_end) begin
                    shift_next = {shift[0], shift[7:1]};
                    if (bit_idx == 3'd7) begin
                        bit_idx_next = '0;
`ifdef UART_TX_PARITY_EN
                        state_next   = ST_PARITY;
`else
                        state_next   = ST_STOP;
`endif
                    end else begin
                        bit_idx_next = bit_idx + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_end) state_next = ST_STOP;
            end
`endif
            ST_STOP: begin
                if (bit_end) begin
                    state_next = ST_IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase

        // TxD is registered from the upcoming state so the line never glitches.
        case (state_next)
            ST_START:  txd_next = 1'b0;
            ST_DATA:   txd_next = shift_next[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: txd_next = ^shift_next;
`endif
            default:   txd_next = 1'b1;
        endcase
    end
endmodule
